// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown scheduler and its arbiter.
package countdown_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward, with
// wrap, starting just after the pointer.
module rr_arbiter
  import countdown_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(pointer) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_scheduler.sv
// Shares one external loadable down-counter among NUM_REQ requesters:
// round-robin grant, load, decrement to zero, then pulse done to the winner.
module countdown_scheduler
  import countdown_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_val,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [WIDTH-1:0]           IN,
  output logic                       latch,
  output logic                       dec,
  input  logic                       zero
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 latch_q, latch_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   onehot;
  logic [WIDTH-1:0]     val_arr [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      val_arr[i] = req_val[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          winner_d = arb_idx;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = COUNT;
      COUNT: begin
        // A dropped request aborts silently; it takes precedence over zero.
        if (!req[winner_q]) begin
          ptr_d   = winner_q;
          state_d = IDLE;
        end else if (zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // gnt_q already holds onehot(winner_q) once a job is under way.
    onehot  = (state_q == IDLE) ? arb_gnt : gnt_q;
    gnt_d   = (state_d != IDLE) ? onehot : '0;
    done_d  = (state_d == DONE) ? onehot : '0;
    latch_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
    end
  end

  // req_val is read only while latch is high, i.e. during LOAD.
  assign IN    = latch_q ? val_arr[winner_q] : '0;
  assign dec   = (state_q == COUNT) && !zero;
  assign gnt   = gnt_q;
  assign done  = done_q;
  assign latch = latch_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler with a behavioural down-counter
// attached to the IN/latch/dec/zero interface.
module tb_countdown_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_val;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  IN;
  logic        latch;
  logic        dec;
  logic        zero;
  logic [3:0]  cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned job    = 0;

  typedef struct {
    logic        pre_rst;
    logic [3:0]  req;
    logic [15:0] val;
    int unsigned idx;
    int unsigned v;
    logic        hold;
  } vec_t;

  vec_t tbl [10];

  countdown_scheduler #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_val (req_val),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .IN      (IN),
    .latch   (latch),
    .dec     (dec),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)        cnt <= 4'd0;
    else if (latch) cnt <= IN;
    else if (dec)   cnt <= cnt - 4'd1;
  end
  assign zero = (cnt == 4'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},   32'(gnt),   32'd0);
    check({tag, " done"},  32'(done),  32'd0);
    check({tag, " latch"}, 32'(latch), 32'd0);
    check({tag, " IN"},    32'(IN),    32'd0);
    check({tag, " dec"},   32'(dec),   32'd0);
    check({tag, " busy"},  32'(busy),  32'd0);
  endtask

  // Full job from the IDLE edge E0; cycle c is sampled #1 after edge E(c-1).
  task automatic run_job(input logic [3:0] r, input logic [15:0] val,
                         input int unsigned idx, input int unsigned v, input logic hold);
    logic [3:0] oh;
    string      t;
    oh      = 4'b0001 << idx;
    req     = r;
    req_val = val;
    job++;
    @(posedge clk); #1;
    for (int unsigned c = 1; c <= v + 4; c++) begin
      t = $sformatf("job%0d c%0d", job, c);
      check({t, " latch"}, 32'(latch), 32'(c == 1));
      check({t, " IN"},    32'(IN),    (c == 1) ? v : 32'd0);
      check({t, " gnt"},   32'(gnt),   (c <= v + 3) ? 32'(oh) : 32'd0);
      check({t, " dec"},   32'(dec),   32'((c >= 2) && (c <= v + 1)));
      check({t, " done"},  32'(done),  (c == v + 3) ? 32'(oh) : 32'd0);
      check({t, " busy"},  32'(busy),  32'(c <= v + 3));
      if (c < v + 4) begin
        @(posedge clk); #1;
      end
    end
    if (!hold) req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 4'b0010, 16'h0030, 1, 3,  1'b0};
    tbl[1] = '{1'b0, 4'b0001, 16'h0000, 0, 0,  1'b0};
    tbl[2] = '{1'b0, 4'b0100, 16'h0F00, 2, 15, 1'b0};
    tbl[3] = '{1'b0, 4'b1000, 16'h2000, 3, 2,  1'b0};
    tbl[4] = '{1'b0, 4'b1001, 16'h5002, 0, 2,  1'b0};
    tbl[5] = '{1'b1, 4'b1111, 16'h1111, 0, 1,  1'b1};
    tbl[6] = '{1'b0, 4'b1111, 16'h1111, 1, 1,  1'b1};
    tbl[7] = '{1'b0, 4'b1111, 16'h1111, 2, 1,  1'b1};
    tbl[8] = '{1'b0, 4'b1111, 16'h1111, 3, 1,  1'b1};
    tbl[9] = '{1'b0, 4'b1111, 16'h1111, 0, 1,  1'b0};

    rst = 1'b1; req = '0; req_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre_rst) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      run_job(tbl[i].req, tbl[i].val, tbl[i].idx, tbl[i].v, tbl[i].hold);
    end

    // Abort: req[2] with V=10 drops after four decrement cycles.
    req = 4'b0100; req_val = 16'h0A00;
    @(posedge clk); #1;
    check("abort latch", 32'(latch), 32'd1);
    check("abort IN",    32'(IN),    32'd10);
    check("abort gnt",   32'(gnt),   32'b0100);
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("abort c%0d dec", c),  32'(dec),  32'd1);
      check($sformatf("abort c%0d done", c), 32'(done), 32'd0);
    end
    req = '0;
    for (int c = 6; c <= 8; c++) begin
      @(posedge clk); #1;
      check_idle($sformatf("abort c%0d", c));
    end
    run_job(4'b1011, 16'h1011, 3, 1, 1'b0);

    // Reset in the middle of a V=14 count, five decrements in.
    req = 4'b0010; req_val = 16'h00E0;
    @(posedge clk); #1;
    check("mrst latch", 32'(latch), 32'd1);
    check("mrst IN",    32'(IN),    32'd14);
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("mrst c%0d dec", c),  32'(dec),  32'd1);
      check($sformatf("mrst c%0d done", c), 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("mrst after");
    run_job(4'b0011, 16'h0012, 0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
